controle_jogada: RTL and testbench

Move controller sitting directly downstream of the move generator. On a start request it pulses `novaJogada` to the generator and captures the `coluna`/`linha` pair the generator returns. It checks that the square is inside the 1..8 board range and not already taken, then either commits the move to a 64-square occupancy map or re-requests, up to a retry limit. Accepted moves are presented to the display/game-logic stage as a one-cycle strobe with the coordinates.

---
 rtl/controle_jogada.sv | 87 ++++++++
 tb/tb_controle_jogada.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogada.sv
// controle_jogada: requests a move from the generator, validates it and commits it to the board.
// Optional occupancy map and occupied-square rejection enabled by CONTROLE_OCUPACAO_EN.
module controle_jogada #(
  parameter int MAX_TENTATIVAS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       limpar,
  input  logic [3:0] coluna,
  input  logic [3:0] linha,
  output logic       novaJogada,
  output logic [3:0] colunaJogada,
  output logic [3:0] linhaJogada,
  output logic       jogadaFeita,
  output logic       erroJogada,
  output logic [6:0] numJogadas,
  output logic       pronto
);
  typedef enum logic [2:0] {OCIOSO, PEDE, ESPERA, VERIFICA, REGISTRA, ERRO} estado_t;
  estado_t estado, proximo;
  logic [3:0] tentativas;
  logic em_faixa, livre, cheio, valida, registra, limpa;
  assign em_faixa = coluna >= 4'd1 && coluna <= 4'd8 && linha >= 4'd1 && linha <= 4'd8;
`ifdef CONTROLE_OCUPACAO_EN
  logic [63:0] mapa;
  logic [5:0] idx;
  assign idx = {linha[2:0] - 3'd1, coluna[2:0] - 3'd1};
  assign livre = em_faixa && !mapa[idx];
  assign cheio = numJogadas == 7'd64;
`else
  assign livre = em_faixa;
  assign cheio = 1'b0;
`endif
  assign valida = em_faixa && livre;
  assign registra = estado == VERIFICA && valida;
  assign limpa = limpar && (estado == OCIOSO || estado == ERRO);
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:   proximo = limpar ? OCIOSO : iniciar ? (cheio ? ERRO : PEDE) : OCIOSO;
      PEDE:     proximo = ESPERA;
      ESPERA:   proximo = VERIFICA;
      VERIFICA: proximo = valida ? REGISTRA : tentativas < 4'(MAX_TENTATIVAS) ? PEDE : ERRO;
      REGISTRA: proximo = OCIOSO;
      ERRO:     proximo = limpar ? OCIOSO : ERRO;
      default:  proximo = OCIOSO;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      tentativas   <= '0;
      novaJogada   <= 1'b0;
      jogadaFeita  <= 1'b0;
      erroJogada   <= 1'b0;
      pronto       <= 1'b1;
      colunaJogada <= '0;
      linhaJogada  <= '0;
      numJogadas   <= '0;
`ifdef CONTROLE_OCUPACAO_EN
      mapa         <= '0;
`endif
    end else begin
      estado      <= proximo;
      novaJogada  <= proximo == PEDE;
      jogadaFeita <= proximo == REGISTRA;
      erroJogada  <= proximo == ERRO;
      pronto      <= proximo == OCIOSO;
      if (estado == OCIOSO && proximo == PEDE) tentativas <= 4'd1;
      else if (estado == VERIFICA && proximo == PEDE) tentativas <= tentativas + 4'd1;
      if (limpa) begin
        numJogadas <= '0;
`ifdef CONTROLE_OCUPACAO_EN
        mapa       <= '0;
`endif
      end else if (registra) begin
        colunaJogada <= coluna;
        linhaJogada  <= linha;
        numJogadas   <= numJogadas + 7'(numJogadas != 7'd64);
`ifdef CONTROLE_OCUPACAO_EN
        mapa[idx]    <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_controle_jogada.sv
// tb_controle_jogada: randomized bench for controle_jogada against a board-level reference model.
// Honours CONTROLE_OCUPACAO_EN the same way the design does.
module tb_controle_jogada;
  localparam int MAX = 8;
`ifdef CONTROLE_OCUPACAO_EN
  localparam bit OCC = 1'b1;
`else
  localparam bit OCC = 1'b0;
`endif
  logic clock = 0, reset = 1, iniciar = 0, limpar = 0;
  logic [3:0] coluna = 0, linha = 0;
  logic novaJogada, jogadaFeita, erroJogada, pronto;
  logic [3:0] colunaJogada, linhaJogada;
  logic [6:0] numJogadas;
  int checks = 0, failures = 0;
  bit occ [8][8];
  int cnt = 0;
  bit last_err;
  logic [3:0] gq_c[$], gq_l[$];

  controle_jogada #(.MAX_TENTATIVAS(MAX)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .limpar(limpar),
    .coluna(coluna), .linha(linha), .novaJogada(novaJogada),
    .colunaJogada(colunaJogada), .linhaJogada(linhaJogada),
    .jogadaFeita(jogadaFeita), .erroJogada(erroJogada),
    .numJogadas(numJogadas), .pronto(pronto)
  );

  always #5 clock = ~clock;

  // Generator: serves the next queued square for each request, holding its last value when empty.
  initial forever begin
    @(negedge clock);
    if (novaJogada === 1'b1 && gq_c.size() > 0) begin
      coluna = gq_c.pop_front();
      linha = gq_l.pop_front();
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit ok_sq(input logic [3:0] c, input logic [3:0] l);
    if (c < 1 || c > 8 || l < 1 || l > 8) return 0;
    if (OCC && occ[l-1][c-1]) return 0;
    return 1;
  endfunction

  task automatic clear_model();
    foreach (occ[i, j]) occ[i][j] = 0;
    cnt = 0;
  endtask

  task automatic push(input logic [3:0] c, input logic [3:0] l);
    gq_c.push_back(c);
    gq_l.push_back(l);
  endtask

  task automatic do_limpar(input string tag);
    limpar = 1;
    @(posedge clock); #1;
    limpar = 0;
    clear_model();
    check({tag, "_pronto"}, pronto, 1);
    check({tag, "_num"}, numJogadas, 0);
  endtask

  task automatic run_move(input string tag);
    logic [3:0] rc[$], rl[$];
    logic [3:0] ec = 0, el = 0;
    int exp_pulses, exp_cyc, cyc, pulses;
    bit exp_ok = 0;
    rc = gq_c;
    rl = gq_l;
    if (OCC && cnt == 64) begin
      exp_pulses = 0;
      exp_cyc = 1;
    end else begin
      exp_pulses = MAX;
      exp_cyc = 3 * MAX + 1;
      for (int k = 0; k < MAX; k++) begin
        logic [3:0] c, l;
        c = k < rc.size() ? rc[k] : rc[rc.size()-1];
        l = k < rl.size() ? rl[k] : rl[rl.size()-1];
        if (ok_sq(c, l)) begin
          exp_ok = 1;
          ec = c;
          el = l;
          exp_pulses = k + 1;
          exp_cyc = 3 * k + 4;
          break;
        end
      end
    end
    iniciar = 1;
    @(posedge clock); #1;
    iniciar = 0;
    cyc = 1;
    pulses = 0;
    check({tag, "_pronto_drop"}, pronto, 0);
    forever begin
      if (novaJogada === 1'b1) pulses++;
      if (jogadaFeita === 1'b1 || erroJogada === 1'b1 || cyc >= 200) break;
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_feita"}, jogadaFeita, exp_ok);
    check({tag, "_erro"}, erroJogada, !exp_ok);
    if (exp_ok) begin
      occ[el-1][ec-1] = 1;
      if (cnt < 64) cnt++;
      check({tag, "_col"}, colunaJogada, ec);
      check({tag, "_lin"}, linhaJogada, el);
    end
    check({tag, "_num"}, numJogadas, cnt);
    gq_c.delete();
    gq_l.delete();
    @(posedge clock); #1;
    if (exp_ok) begin
      check({tag, "_pronto_back"}, pronto, 1);
      check({tag, "_feita_pulse"}, jogadaFeita, 0);
    end else begin
      check({tag, "_erro_hold"}, erroJogada, 1);
    end
    last_err = !exp_ok;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_pronto", pronto, 1);
    check("rst_nova", novaJogada, 0);
    check("rst_feita", jogadaFeita, 0);
    check("rst_erro", erroJogada, 0);
    check("rst_num", numJogadas, 0);
    check("rst_col", colunaJogada, 0);
    check("rst_lin", linhaJogada, 0);
    reset = 0;
    @(posedge clock); #1;
    push(2, 2);
    run_move("first");
    push(2, 2);
    run_move("dup");
    if (last_err) do_limpar("dup_clr");
    push(0, 5); push(9, 3); push(8, 8);
    run_move("range");
    for (int m = 0; m < 40; m++) begin
      for (int k = 0; k < MAX; k++) begin
        if ($urandom_range(0, 9) < 3) begin
          int v = $urandom_range(9, 16);
          push(4'(v == 16 ? 0 : v), 4'($urandom_range(0, 15)));
        end else push(4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)));
      end
      run_move("rnd");
      if (last_err || $urandom_range(0, 9) == 0) do_limpar("rnd_clr");
    end
    do_limpar("fill_clr");
    for (int s = 0; s < 64; s++) begin
      push(0, 4'(s / 8 + 1));
      push(4'(s % 8 + 1), 4'(s / 8 + 1));
      run_move("fill");
    end
    push(1, 1);
    run_move("full");
    do_limpar("full_clr");
    push(2, 2);
    run_move("pre_rst");
    push(3, 3);
    iniciar = 1;
    @(posedge clock); #1;
    iniciar = 0;
    @(posedge clock); #1;
    check("esp_pronto", pronto, 0);
    reset = 1;
    #1;
    check("mid_pronto", pronto, 1);
    check("mid_nova", novaJogada, 0);
    check("mid_num", numJogadas, 0);
    check("mid_col", colunaJogada, 0);
    check("mid_lin", linhaJogada, 0);
    @(posedge clock); #1;
    reset = 0;
    clear_model();
    gq_c.delete();
    gq_l.delete();
    push(2, 2);
    run_move("post_rst");
    do_limpar("both_pre");
    for (int k = 0; k < 5; k++) begin
      push(4'(k + 1), 1);
      run_move("five");
    end
    check("five_num", numJogadas, 5);
    iniciar = 1;
    limpar = 1;
    @(posedge clock); #1;
    iniciar = 0;
    limpar = 0;
    clear_model();
    check("both_num", numJogadas, 0);
    check("both_pronto", pronto, 1);
    begin
      int p = 0;
      repeat (4) begin
        if (novaJogada === 1'b1) p++;
        @(posedge clock); #1;
      end
      check("both_nova", p, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
